// File: rtl/pcs_in_sel.sv
// pcs_in_sel: receive-side PMA input select.
// Optional polarity inversion, then either PN-2112 descrambling aligned to the
// 33-word FEC codeword (FEC mode) or straight pass-through to the 66b gearbox.
// Fixed 2-cycle latency from PMA_RX_BLK to either output bus.
// Optional feature macro: PCS_IN_SEL_SLIP_CNT_EN adds the SLIP_CNT port and a
// saturating codeword-realignment counter.
module pcs_in_sel #(
  parameter logic [57:0] PN_SEED  = 58'h3,
  parameter int unsigned CW_WORDS = 33
) (
  input  logic        CLK219,
  input  logic        RST219,
  input  logic [63:0] PMA_RX_BLK,
  input  logic        FEC_CW_START,
  input  logic        FEC_BLK_LOCK,
  input  logic        CSR_PCS_DEC_FEC_ENA,
  input  logic        CSR_DEC_INV,
  output logic [63:0] DEC_FEC_BLK,
  output logic        DEC_FEC_BLK_VLD,
  output logic        DEC_FEC_BLK_SOC,
  output logic [5:0]  DEC_FEC_WORD_IDX,
`ifdef PCS_IN_SEL_SLIP_CNT_EN
  output logic [15:0] SLIP_CNT,
`endif
  output logic [63:0] DEC_GB66_BLK,
  output logic        DEC_GB66_VLD
);

  localparam logic [5:0] LastIdx = 6'(CW_WORDS - 1);

  // Expands a 58-bit PN state into 122 sequence bits: [63:0] is this word's
  // mask, [121:64] is the state for the following word.
  function automatic logic [121:0] pn_expand(input logic [57:0] s);
    logic [121:0] e;
    e       = '0;
    e[57:0] = s;
    for (int n = 58; n < 122; n++) begin
      e[n] = e[n-58] ^ e[n-39];
    end
    return e;
  endfunction

  // CSR synchronizers and mode-change history
  logic fec_meta, fec_ena, inv_meta, dec_inv;
  logic fec_q, flush_q;

  // Counter / generator state
  logic [5:0]   cnt_q, cnt_d;
  logic [57:0]  pn_q, pn_d;
  logic [5:0]   cur_idx;
  logic [57:0]  pn_cur;
  logic [121:0] pn_ext;
  logic         run;
  logic         kill;

  // Stage 1
  logic [63:0] inv_blk, mask1;
  logic [5:0]  idx1;
  logic        soc1, lock1, fec1, kill1;

  // Two-flop level synchronizers for the asynchronous CSR bits
  always_ff @(posedge CLK219) begin
    if (RST219) begin
      fec_meta <= 1'b0;
      fec_ena  <= 1'b0;
      inv_meta <= 1'b0;
      dec_inv  <= 1'b0;
    end else begin
      fec_meta <= CSR_PCS_DEC_FEC_ENA;
      fec_ena  <= fec_meta;
      inv_meta <= CSR_DEC_INV;
      dec_inv  <= inv_meta;
    end
  end

  // Remember fec_ena so a mode change kills this word and the next one
  always_ff @(posedge CLK219) begin
    if (RST219) begin
      fec_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      fec_q   <= fec_ena;
      flush_q <= (fec_ena != fec_q);
    end
  end

  assign kill = (fec_ena != fec_q) || flush_q;

  // Word index and PN state for the incoming word, plus next-state
  always_comb begin
    run     = FEC_BLK_LOCK && fec_ena;
    cur_idx = cnt_q;
    pn_cur  = pn_q;
    // Start with lock realigns immediately, even mid-codeword
    if (!run || FEC_CW_START) begin
      cur_idx = 6'd0;
      pn_cur  = PN_SEED;
    end
    pn_ext = pn_expand(pn_cur);
    if (!run) begin
      cnt_d = 6'd0;
      pn_d  = PN_SEED;
    end else if (cur_idx == LastIdx) begin
      cnt_d = 6'd0;
      pn_d  = PN_SEED;
    end else begin
      cnt_d = cur_idx + 6'd1;
      pn_d  = pn_ext[121:64];
    end
  end

  // Word counter and PN generator state
  always_ff @(posedge CLK219) begin
    if (RST219) begin
      cnt_q <= 6'd0;
      pn_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      pn_q  <= pn_d;
    end
  end

`ifdef PCS_IN_SEL_SLIP_CNT_EN
  // Count codeword starts that arrive off the expected boundary
  always_ff @(posedge CLK219) begin
    if (RST219) begin
      SLIP_CNT <= 16'd0;
    end else if (fec_ena && !fec_q) begin
      SLIP_CNT <= 16'd0;
    end else if (FEC_CW_START && FEC_BLK_LOCK && fec_ena && (cnt_q != 6'd0) &&
                 (SLIP_CNT != 16'hFFFF)) begin
      SLIP_CNT <= SLIP_CNT + 16'd1;
    end
  end
`endif

  // Stage 1: polarity inversion with index, SOC, mask and mode alongside
  always_ff @(posedge CLK219) begin
    if (RST219) begin
      inv_blk <= '0;
      mask1   <= '0;
      idx1    <= 6'd0;
      soc1    <= 1'b0;
      lock1   <= 1'b0;
      fec1    <= 1'b0;
      kill1   <= 1'b0;
    end else begin
      inv_blk <= dec_inv ? ~PMA_RX_BLK : PMA_RX_BLK;
      mask1   <= pn_ext[63:0];
      idx1    <= cur_idx;
      soc1    <= run && (cur_idx == 6'd0);
      lock1   <= FEC_BLK_LOCK;
      fec1    <= fec_ena;
      kill1   <= kill;
    end
  end

  // Stage 2: steer to the FEC decoder or the 66b gearbox
  always_ff @(posedge CLK219) begin
    if (RST219) begin
      DEC_FEC_BLK      <= '0;
      DEC_FEC_BLK_VLD  <= 1'b0;
      DEC_FEC_BLK_SOC  <= 1'b0;
      DEC_FEC_WORD_IDX <= 6'd0;
      DEC_GB66_BLK     <= '0;
      DEC_GB66_VLD     <= 1'b0;
    end else begin
      if (fec1) begin
        DEC_FEC_BLK      <= inv_blk ^ mask1;
        DEC_FEC_WORD_IDX <= idx1;
      end else begin
        DEC_GB66_BLK <= inv_blk;
      end
      DEC_FEC_BLK_VLD <= fec1 && lock1 && !kill1;
      DEC_FEC_BLK_SOC <= fec1 && soc1 && !kill1;
      DEC_GB66_VLD    <= !fec1 && !kill1;
    end
  end

endmodule

// File: doc/pcs_in_sel.md
Name: pcs_in_sel

Overview:
- Receive-side counterpart of the encoder PMA output select.
- Takes the 64-bit PMA receive word and applies optional polarity inversion.
- In FEC mode it removes the PN-2112 scrambling mask, aligned to the 33-word FEC codeword boundary supplied by FEC block sync, and hands words to the FEC decoder.
- In non-FEC mode it passes words to the 66b receive gearbox.

Parameters:
- PN_SEED, 58'h3, PN-2112 generator seed loaded at each codeword start.
- CW_WORDS, 33, 64-bit words per 2112-bit FEC codeword.

Ports:
- CLK219  in  1  receive PCS clock.
- RST219  in  1  synchronous active-high reset.
- PMA_RX_BLK  in  64  PMA receive word, one per cycle; bit 0 is first in time.
- FEC_CW_START  in  1  pulse: PMA_RX_BLK this cycle is word 0 of a codeword.
- FEC_BLK_LOCK  in  1  FEC block sync locked.
- CSR_PCS_DEC_FEC_ENA  in  1  async CSR, FEC mode enable.
- CSR_DEC_INV  in  1  async CSR, invert received data.
- DEC_FEC_BLK  out  64  descrambled FEC word.
- DEC_FEC_BLK_VLD  out  1  DEC_FEC_BLK valid.
- DEC_FEC_BLK_SOC  out  1  DEC_FEC_BLK is codeword word 0.
- DEC_FEC_WORD_IDX  out  6  word index 0..CW_WORDS-1.
- DEC_GB66_BLK  out  64  word to 66b gearbox.
- DEC_GB66_VLD  out  1  DEC_GB66_BLK valid.

Behaviour:
- Single clock CLK219; reset RST219 is synchronous, active-high. All outputs and state reset to 0.
- CSR inputs pass through 2-flop level synchronizers (vi_sync_level) to give fec_ena and dec_inv. Reset value of each synchronizer is 0.

Pipeline:
- Stage 1: inv_blk <= dec_inv ? ~PMA_RX_BLK : PMA_RX_BLK. Register the word index and SOC with it.
- Stage 2 drives the outputs. Fixed latency is 2 cycles from PMA_RX_BLK to either output bus.

Word counter (idx, 0..CW_WORDS-1):
- If FEC_BLK_LOCK=0 or fec_ena=0, force idx to 0 and hold the generator at seed.
- If FEC_CW_START=1 and lock=1, the current word gets idx 0 and the generator is reseeded. If idx was not at the expected boundary (a slip), the realignment takes effect immediately.
- Otherwise idx increments and wraps from CW_WORDS-1 to 0. Wrap reseeds the generator even without FEC_CW_START.

PN-2112 sequence:
- p[0..57] = PN_SEED[0..57]; p[n] = p[n-58] ^ p[n-39] for n>=58.
- Mask for word k, bit j is p[64k+j].
- Implement as a 58-bit state advanced 64 bits per cycle, with a parallel next-state computed combinationally.
- Reseed loads the state so the mask for word 0 is produced in the same cycle.

FEC path (fec_ena=1):
- DEC_FEC_BLK <= inv_blk ^ mask.
- DEC_FEC_BLK_VLD = stage-1 lock.
- DEC_FEC_BLK_SOC = 1 when stage-1 idx = 0 and lock.
- DEC_GB66_VLD = 0; DEC_GB66_BLK holds its last value.

Non-FEC path (fec_ena=0):
- DEC_GB66_BLK <= inv_blk; DEC_GB66_VLD = 1 every cycle once out of reset.
- DEC_FEC_BLK_VLD and DEC_FEC_BLK_SOC = 0.

Boundary conditions:
- A change of fec_ena flushes: that cycle and the next, both VLD outputs = 0. idx restarts at 0 and waits for FEC_CW_START or wraps naturally.
- A lock drop mid-codeword deasserts VLD at the output 2 cycles later; the partial codeword is discarded.
- FEC_CW_START with lock=0 is ignored.
- Reset mid-codeword clears everything within 1 cycle.

Optional Feature:
- Macro: PCS_IN_SEL_SLIP_CNT_EN.
- Defined:
  - Adds output port SLIP_CNT [15:0].
  - Saturating counter increments when FEC_CW_START=1, lock=1, fec_ena=1 and the expected idx is not 0.
  - Counter clears on reset and on a rising edge of fec_ena.
- Undefined: no port, no counter logic.

Test Plan:
- Reset → all outputs 0 in the first cycle after reset while RST219=1.
- FEC on, no inversion, PMA_RX_BLK=0, FEC_CW_START at T → at T+2: DEC_FEC_BLK=64'h0C00_0000_0000_0003, SOC=1, IDX=0, VLD=1.
- Same setup plus CSR_DEC_INV=1 → DEC_FEC_BLK=64'hF3FF_FFFF_FFFF_FFFC. 33 words later SOC=1 again with no further FEC_CW_START, and the mask repeats.
- FEC off, inversion off, PMA_RX_BLK=64'h0123_4567_89AB_CDEF → DEC_GB66_BLK equals it 2 cycles later with GB66_VLD=1, FEC VLD=0. With inversion on → 64'hFEDC_BA98_7654_3210.
- FEC on, FEC_CW_START at T and again at T+10 → IDX goes 0..9, then 0 at T+12 with the mask reseeded. SLIP_CNT=1 when the macro is defined.
- FEC_BLK_LOCK drops at idx 15 → VLD low 2 cycles later. Lock returns with FEC_CW_START → SOC=1 and the word-0 mask is correct.
